regfile_nrport: RTL and testbench

//  Parametrised register file: one synchronous write port, NUM_RD registered read ports.

---
 rtl/regfile_nrport.sv | 141 ++++++++++++++
 tb/tb_regfile_nrport.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_nrport.sv
// rtl/regfile_nrport.sv - register file, one write port, NUM_RD registered read ports, clear sweep
//
// Purpose:
//   Sits between decode/writeback and operand fetch. Writes are address
//   decoded into the array. Each read port is an address-indexed mux with a
//   registered output, so read latency is one cycle. Entry 0 is optionally
//   hardwired to zero. A clear engine zeroes one entry per cycle on request.
//
// Optional feature (macro REGFILE_BYPASS_EN):
//   defined   : write-through; an accepted write to the address being read
//               is returned by that read port at latency 1.
//   undefined : read-before-write; the read port returns the old contents.
//
// Ports:
//   clk         in   1              rising-edge clock
//   rst_n       in   1              synchronous active-low reset
//   wr_en       in   1              write request
//   wr_addr     in   ADDR_W         write address
//   wr_data     in   WIDTH          write data
//   rd_addr     in   NUM_RD*ADDR_W  packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rd_data     out  NUM_RD*WIDTH   packed registered read data, port i at [i*WIDTH +: WIDTH]
//   clr_req     in   1              start clear sweep (sampled in IDLE only)
//   clr_busy    out  1              clear sweep in progress
//   wr_dropped  out  1              pulse: previous-cycle write refused because of a sweep

module regfile_nrport #(
   parameter int WIDTH    = 32,
   parameter int DEPTH    = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       wr_en,
   input  logic [ADDR_W-1:0]          wr_addr,
   input  logic [WIDTH-1:0]           wr_data,
   input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
   output logic [NUM_RD*WIDTH-1:0]    rd_data,
   input  logic                       clr_req,
   output logic                       clr_busy,
   output logic                       wr_dropped
);

   // One extra bit so the range check works even when 2**ADDR_W == DEPTH.
   localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t              state, state_nxt;
   logic [ADDR_W-1:0]   ptr, ptr_nxt;
   logic                wr_ok;
   logic                clr_en;
   logic [WIDTH-1:0]    mem [DEPTH];
   logic [WIDTH-1:0]    rd_val [NUM_RD];

   // An address is backed by storage if it is in range and not the hardwired zero entry.
   function automatic logic addr_live(input logic [ADDR_W-1:0] a);
      return ({1'b0, a} < DEPTH_W) && !((ZERO_REG != 0) && (a == '0));
   endfunction

   // ---------------- clear FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         ptr   <= '0;
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
      end
   end

   // ---------------- clear FSM: next state ----------------
   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      case (state)
         IDLE: begin
            if (clr_req) begin
               state_nxt = CLEAR;
               ptr_nxt   = '0;
            end
         end
         CLEAR: begin
            // clr_req is deliberately not looked at here: no restart, no queueing.
            if (ptr == LAST_PTR) begin
               state_nxt = IDLE;
               ptr_nxt   = '0;
            end else begin
               ptr_nxt   = ptr + ADDR_W'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
            ptr_nxt   = '0;
         end
      endcase
   end

   // ---------------- clear FSM: outputs ----------------
   always_comb begin
      clr_busy = (state == CLEAR);
      clr_en   = (state == CLEAR);
      // Writes are only taken in IDLE, so they never collide with the sweep pointer.
      wr_ok    = wr_en && (state == IDLE) && addr_live(wr_addr);
   end

   // ---------------- read muxes ----------------
   always_comb begin
      for (int i = 0; i < NUM_RD; i++) begin
         rd_val[i] = '0;
         if (addr_live(rd_addr[i*ADDR_W +: ADDR_W]))
            rd_val[i] = mem[rd_addr[i*ADDR_W +: ADDR_W]];
`ifdef REGFILE_BYPASS_EN
         // wr_ok already excludes refused, out-of-range and zero-entry writes.
         if (wr_ok && (wr_addr == rd_addr[i*ADDR_W +: ADDR_W]))
            rd_val[i] = wr_data;
`endif
      end
   end

   // ---------------- storage and registered outputs ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int j = 0; j < DEPTH; j++)
            mem[j] <= '0;
         rd_data    <= '0;
         wr_dropped <= 1'b0;
      end else begin
         wr_dropped <= wr_en && (state == CLEAR);
         for (int i = 0; i < NUM_RD; i++)
            rd_data[i*WIDTH +: WIDTH] <= rd_val[i];
         if (wr_ok)
            mem[wr_addr] <= wr_data;
         if (clr_en)
            mem[ptr] <= '0;
      end
   end

endmodule

// File: tb/tb_regfile_nrport.sv
// tb/tb_regfile_nrport.sv - directed self-checking bench for regfile_nrport

module tb_regfile_nrport;

   localparam int WIDTH  = 32;
   localparam int DEPTH  = 32;
   localparam int ADDR_W = 5;
   localparam int NUM_RD = 2;

   logic                      clk;
   logic                      rst_n;
   logic                      wr_en;
   logic [ADDR_W-1:0]         wr_addr;
   logic [WIDTH-1:0]          wr_data;
   logic [NUM_RD*ADDR_W-1:0]  rd_addr;
   logic [NUM_RD*WIDTH-1:0]   rd_data;
   logic                      clr_req;
   logic                      clr_busy;
   logic                      wr_dropped;

   logic [WIDTH-1:0]          rd0, rd1;
   assign rd0 = rd_data[WIDTH-1:0];
   assign rd1 = rd_data[2*WIDTH-1:WIDTH];

   int n_checks = 0;
   int n_fail   = 0;

   regfile_nrport #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .ZERO_REG(1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr(rd_addr), .rd_data(rd_data), .clr_req(clr_req), .clr_busy(clr_busy),
      .wr_dropped(wr_dropped)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_rd(input int a0, input int a1);
      rd_addr[ADDR_W-1:0]        = ADDR_W'(a0);
      rd_addr[2*ADDR_W-1:ADDR_W] = ADDR_W'(a1);
   endtask

   task automatic wr_word(input int a, input logic [WIDTH-1:0] d);
      wr_en   = 1'b1;
      wr_addr = ADDR_W'(a);
      wr_data = d;
      tick();
      wr_en   = 1'b0;
   endtask

   task automatic fill_all();
      for (int a = 0; a < DEPTH; a++)
         wr_word(a, WIDTH'(a + 1));
   endtask

   task automatic test_reset();
      for (int k = 0; k < 8; k++)
         wr_word(int'($urandom_range(1, DEPTH - 1)), $urandom());
      set_rd(5, 9);
      rst_n = 1'b0;
      tick();
      tick();
      n_checks++;
      if (clr_busy !== 1'b0 || wr_dropped !== 1'b0 || rd_data !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs busy=%b dropped=%b rd_data=%h required 0/0/0", clr_busy, wr_dropped, rd_data);
      end
      rst_n = 1'b1;
      for (int a = 0; a < DEPTH; a++) begin
         set_rd(a, DEPTH - 1 - a);
         tick();
         n_checks++;
         if (rd0 !== '0 || rd1 !== '0) begin
            n_fail++;
            $display("FAIL reset_contents addr=%0d got=%h/%h required 0", a, rd0, rd1);
         end
      end
   endtask

   task automatic test_write_read();
      wr_word(5, 32'hDEADBEEF);
      set_rd(5, 5);
      tick();
      n_checks++;
      if (rd0 !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL write_read port0 got=%h required deadbeef", rd0);
      end
      n_checks++;
      if (rd1 !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL same_addr port1 got=%h required deadbeef", rd1);
      end
      wr_word(6, 32'h0BADF00D);
      set_rd(6, 5);
      tick();
      n_checks++;
      if (rd0 !== 32'h0BADF00D || rd1 !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL independent_ports got=%h/%h required 0badf00d/deadbeef", rd0, rd1);
      end
   endtask

   task automatic test_zero_reg();
      set_rd(0, 0);
      wr_word(0, 32'h1234);
      n_checks++;
      if (wr_dropped !== 1'b0) begin
         n_fail++;
         $display("FAIL zero_reg_dropped got=%b required 0", wr_dropped);
      end
      tick();
      n_checks++;
      if (rd0 !== '0 || rd1 !== '0) begin
         n_fail++;
         $display("FAIL zero_reg_read got=%h/%h required 0", rd0, rd1);
      end
   endtask

   task automatic test_bypass();
      logic [WIDTH-1:0] exp;
      wr_word(7, 32'h11);
      set_rd(0, 7);
      wr_word(7, 32'hA5A5A5A5);
`ifdef REGFILE_BYPASS_EN
      exp = 32'hA5A5A5A5;
`else
      exp = 32'h11;
`endif
      n_checks++;
      if (rd1 !== exp) begin
         n_fail++;
         $display("FAIL same_cycle_rw got=%h required %h", rd1, exp);
      end
      tick();
      n_checks++;
      if (rd1 !== 32'hA5A5A5A5) begin
         n_fail++;
         $display("FAIL rw_followup got=%h required a5a5a5a5", rd1);
      end
   endtask

   task automatic test_clear();
      int cnt;
      fill_all();
      set_rd(31, 0);
      tick();
      n_checks++;
      if (rd0 !== 32'd32 || rd1 !== '0) begin
         n_fail++;
         $display("FAIL fill_check got=%h/%h required 20/0", rd0, rd1);
      end
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      cnt = 0;
      while (clr_busy === 1'b1 && cnt < 100) begin
         cnt++;
         if (cnt == 5) begin
            wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h77;
            set_rd(3, 0);
         end
         if (cnt == 10) clr_req = 1'b1;
         if (cnt == 20) set_rd(31, 2);
         tick();
         if (cnt == 5) begin
            wr_en = 1'b0;
            n_checks++;
            if (wr_dropped !== 1'b1 || rd0 !== '0) begin
               n_fail++;
               $display("FAIL sweep_write dropped=%b rd=%h required 1/0", wr_dropped, rd0);
            end
         end
         if (cnt == 6) begin
            n_checks++;
            if (wr_dropped !== 1'b0) begin
               n_fail++;
               $display("FAIL dropped_pulse_width got=%b required 0", wr_dropped);
            end
         end
         if (cnt == 11) clr_req = 1'b0;
         if (cnt == 20) begin
            n_checks++;
            if (rd0 !== 32'd32 || rd1 !== '0) begin
               n_fail++;
               $display("FAIL read_during_sweep got=%h/%h required 20/0", rd0, rd1);
            end
         end
      end
      n_checks++;
      if (cnt != DEPTH) begin
         n_fail++;
         $display("FAIL busy_cycles got=%0d required %0d", cnt, DEPTH);
      end
      for (int a = 0; a < DEPTH; a++) begin
         set_rd(a, DEPTH - 1 - a);
         tick();
         n_checks++;
         if (rd0 !== '0 || rd1 !== '0) begin
            n_fail++;
            $display("FAIL after_sweep addr=%0d got=%h/%h required 0", a, rd0, rd1);
         end
      end
   endtask

   task automatic test_reset_mid_sweep();
      int cnt;
      wr_word(9, 32'h99);
      wr_word(20, 32'h20);
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      for (int k = 1; k < 10; k++) tick();
      rst_n = 1'b0;
      tick();
      n_checks++;
      if (clr_busy !== 1'b0 || wr_dropped !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_sweep busy=%b dropped=%b required 0/0", clr_busy, wr_dropped);
      end
      rst_n = 1'b1;
      set_rd(9, 20);
      tick();
      n_checks++;
      if (rd0 !== '0 || rd1 !== '0) begin
         n_fail++;
         $display("FAIL reset_mid_sweep_contents got=%h/%h required 0", rd0, rd1);
      end
      wr_word(20, 32'h5);
      tick();
      n_checks++;
      if (rd1 !== 32'h5) begin
         n_fail++;
         $display("FAIL idle_after_reset_write got=%h required 5", rd1);
      end
      // write taken in the same cycle as clr_req: accepted, then swept
      clr_req = 1'b1;
      set_rd(25, 20);
      wr_word(25, 32'hCAFE);
      clr_req = 1'b0;
      n_checks++;
      if (wr_dropped !== 1'b0 || clr_busy !== 1'b1) begin
         n_fail++;
         $display("FAIL clr_with_write dropped=%b busy=%b required 0/1", wr_dropped, clr_busy);
      end
      cnt = 0;
      while (clr_busy === 1'b1 && cnt < 100) begin
         cnt++;
         tick();
         if (cnt == 1) begin
            n_checks++;
            if (rd0 !== 32'hCAFE) begin
               n_fail++;
               $display("FAIL clr_write_accepted got=%h required cafe", rd0);
            end
         end
      end
      n_checks++;
      if (cnt != DEPTH) begin
         n_fail++;
         $display("FAIL resweep_cycles got=%0d required %0d", cnt, DEPTH);
      end
      tick();
      n_checks++;
      if (rd0 !== '0 || rd1 !== '0) begin
         n_fail++;
         $display("FAIL resweep_contents got=%h/%h required 0", rd0, rd1);
      end
   endtask

   initial begin
      rst_n   = 1'b0;
      wr_en   = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      rd_addr = '0;
      clr_req = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      test_reset();
      test_write_read();
      test_zero_reg();
      test_bypass();
      test_clear();
      test_reset_mid_sweep();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
